// File: rtl/spi_dac.sv
// spi_dac: dual-channel 12-bit DAC frame driver, both channels shifted in lockstep.
// Define SPI_DAC_DOUBLE_BUFFER_EN to add a one-entry pending sample buffer.
module spi_dac #(
  parameter int unsigned CLK_DIV = 10,
  parameter logic [1:0]  PD_MODE = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [11:0] data0_i,
  input  logic [11:0] data1_i,
  output logic        spi_sync_no,
  output logic        spi_sck_o,
  output logic [1:0]  spi_mosi_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic        sck_q, sck_d;
  logic        sync_q, sync_d;
  logic [1:0]  mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [15:0] sh0_q, sh0_d;
  logic [15:0] sh1_q, sh1_d;
  logic        rdy_en_q, rdy_en_d;

  logic        div_last;
  logic        accept;
  logic        hold_end;
  logic        rise_e;
  logic        fall_e;
  logic        end_frame;
  logic        frame_go;
  logic        pend_avail;
  logic [11:0] src0, src1;
  logic [15:0] word0, word1;

  assign div_last  = (div_q == DIV_LAST);
  assign accept    = valid_i && ready_o;
  assign hold_end  = (state_q == HOLD) && div_last;
  assign rise_e    = (state_q == SHIFT) && div_last && !sck_q;
  assign fall_e    = (state_q == SHIFT) && div_last && sck_q;
  assign end_frame = fall_e && (bit_q == 4'd0);
  assign frame_go  = ((state_q == IDLE) && accept)
                   || (hold_end && (pend_avail || accept));
  assign word0     = {2'b00, PD_MODE, src0};
  assign word1     = {2'b00, PD_MODE, src1};

`ifdef SPI_DAC_DOUBLE_BUFFER_EN
  logic        pend_vld_q, pend_vld_d;
  logic [11:0] pend0_q, pend0_d;
  logic [11:0] pend1_q, pend1_d;
  logic        use_pend;

  assign pend_avail = pend_vld_q;
  assign use_pend   = hold_end && pend_vld_q;
  assign src0       = use_pend ? pend0_q : data0_i;
  assign src1       = use_pend ? pend1_q : data1_i;

  // An accept that does not start a frame directly parks in the buffer.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend0_d    = pend0_q;
    pend1_d    = pend1_q;
    if (use_pend) begin
      pend_vld_d = 1'b0;
    end
    if (accept && !frame_go) begin
      pend_vld_d = 1'b1;
      pend0_d    = data0_i;
      pend1_d    = data1_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend0_q    <= '0;
      pend1_q    <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
    end
  end
`else
  assign pend_avail = 1'b0;
  assign src0       = data0_i;
  assign src1       = data1_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sck_q    <= 1'b1;
      sync_q   <= 1'b1;
      mosi_q   <= 2'b00;
      done_q   <= 1'b0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sck_q    <= sck_d;
      sync_q   <= sync_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (frame_go) state_d = SETUP;
      SETUP: if (div_last) state_d = SHIFT;
      SHIFT: if (end_frame) state_d = HOLD;
      HOLD:  if (div_last) state_d = frame_go ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d    = div_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    sync_d   = sync_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    rdy_en_d = 1'b1;

    if (state_q != IDLE) begin
      div_d = div_last ? 8'd0 : div_q + 8'd1;
    end
    if ((state_q == SETUP) && div_last) begin
      sck_d = 1'b0;
    end
    // Data moves on SCK rise so it is settled across the sampling fall.
    if (rise_e) begin
      sck_d = 1'b1;
      if (bit_q != 4'd0) begin
        sh0_d  = sh0_q << 1;
        sh1_d  = sh1_q << 1;
        mosi_d = {sh1_q[14], sh0_q[14]};
      end
    end
    if (fall_e) begin
      if (bit_q == 4'd0) begin
        sync_d = 1'b1;
        mosi_d = 2'b00;
        done_d = 1'b1;
      end else begin
        sck_d = 1'b0;
        bit_d = bit_q - 4'd1;
      end
    end
    if (frame_go) begin
      sh0_d  = word0;
      sh1_d  = word1;
      mosi_d = {word1[15], word0[15]};
      sync_d = 1'b0;
      sck_d  = 1'b1;
      bit_d  = 4'd15;
      div_d  = 8'd0;
    end
  end

  always_comb begin
`ifdef SPI_DAC_DOUBLE_BUFFER_EN
    ready_o = rdy_en_q && !pend_vld_q;
`else
    ready_o = rdy_en_q && (state_q == IDLE);
`endif
    spi_sync_no = sync_q;
    spi_sck_o   = sck_q;
    spi_mosi_o  = mosi_q;
    done_o      = done_q;
  end

endmodule

// File: tb/tb_spi_dac.sv
// tb_spi_dac: scoreboard bench for spi_dac; frames decoded on SCK falls.
// Expected words are queued at accept and popped when a frame is decoded.
module tb_spi_dac;

  localparam int         CLK_DIV = 10;
  localparam logic [1:0] PD_MODE = 2'b00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [11:0] data0_i = '0;
  logic [11:0] data1_i = '0;
  logic        spi_sync_no;
  logic        spi_sck_o;
  logic [1:0]  spi_mosi_o;
  logic        done_o;

  int checks = 0;
  int failures = 0;

  spi_dac #(
    .CLK_DIV(CLK_DIV),
    .PD_MODE(PD_MODE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data0_i(data0_i),
    .data1_i(data1_i),
    .spi_sync_no(spi_sync_no),
    .spi_sck_o(spi_sck_o),
    .spi_mosi_o(spi_mosi_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];

  logic        m_sck = 1'b1;
  logic        m_sync = 1'b1;
  logic [1:0]  m_mosi = 2'b00;
  logic        m_rdy = 1'b0;
  logic [15:0] msh0 = '0;
  logic [15:0] msh1 = '0;
  int nbits = 0;
  int lo_cnt = 0;
  int hi_cnt = 0;
  int low_len = -1;
  int high_len = -1;
  int fall_cyc = -1;
  int sck_fall_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  int rdy_cyc = -1;
  int busy_rdy = 0;
  int viol = 0;

  // Bus monitor: decodes the frame as the DAC would and records timing.
  always @(negedge clk) begin
    m_sck  <= spi_sck_o;
    m_sync <= spi_sync_no;
    m_mosi <= spi_mosi_o;
    m_rdy  <= ready_o;
    if (spi_sync_no) begin
      nbits  <= 0;
      hi_cnt <= m_sync ? hi_cnt + 1 : 1;
    end else begin
      lo_cnt <= m_sync ? 1 : lo_cnt + 1;
      if (m_sck && !spi_sck_o) begin
        msh0  <= {msh0[14:0], spi_mosi_o[0]};
        msh1  <= {msh1[14:0], spi_mosi_o[1]};
        nbits <= nbits + 1;
        if (nbits == 0) sck_fall_cyc <= cyc;
        if (nbits == 15)
          rx_q.push_back({msh1[14:0], spi_mosi_o[1],
                          msh0[14:0], spi_mosi_o[0]});
      end
    end
    if (m_sync && !spi_sync_no) begin
      fall_cyc <= cyc;
      high_len <= hi_cnt;
    end
    if (!m_sync && spi_sync_no) low_len <= lo_cnt;
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!m_rdy && ready_o) rdy_cyc <= cyc;
    if (!spi_sync_no && ready_o) busy_rdy <= busy_rdy + 1;
    if (spi_mosi_o !== m_mosi && m_sync === spi_sync_no
        && !(!m_sck && spi_sck_o))
      viol <= viol + 1;
  end

  task automatic accept_pair(input logic [11:0] d0, input logic [11:0] d1,
                             input logic hold, output int acc,
                             output int waited);
    int n = 0;
    @(negedge clk);
    valid_i = 1'b1;
    data0_i = d0;
    data1_i = d1;
    while (!ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    waited = n;
    exp_q.push_back({2'b00, PD_MODE, d1, 2'b00, PD_MODE, d0});
    if (!hold) valid_i = 1'b0;
  endtask

  task automatic get_frame(output logic [31:0] rx, output logic [31:0] ex);
    int n = 0;
    while (rx_q.size() == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    rx = (rx_q.size() != 0) ? rx_q.pop_front() : 'x;
    ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (spi_sync_no !== 1'b1) begin
      failures++;
      $display("FAIL rst_sync got=%b exp=1", spi_sync_no);
    end
    checks++;
    if (spi_sck_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_sck got=%b exp=1", spi_sck_o);
    end
    checks++;
    if (spi_mosi_o !== 2'b00) begin
      failures++;
      $display("FAIL rst_mosi got=%b exp=00", spi_mosi_o);
    end
    checks++;
    if (done_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_done got=%b exp=0", done_o);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=0", ready_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_release_ready got=%b exp=1", ready_o);
    end
  endtask

  task automatic test_basic();
    int a, w, dc, br;
    logic [31:0] rx, ex;
    dc = done_cnt;
    br = busy_rdy;
    accept_pair(12'hA5C, 12'h3FF, 1'b0, a, w);
    get_frame(rx, ex);
    repeat (40) @(negedge clk);
    checks++;
    if (rx[15:0] !== ex[15:0]) begin
      failures++;
      $display("FAIL basic_ch0 got=%h exp=%h", rx[15:0], ex[15:0]);
    end
    checks++;
    if (rx[31:16] !== ex[31:16]) begin
      failures++;
      $display("FAIL basic_ch1 got=%h exp=%h", rx[31:16], ex[31:16]);
    end
    checks++;
    if (fall_cyc !== a) begin
      failures++;
      $display("FAIL basic_sync_fall got=%0d exp=%0d", fall_cyc, a);
    end
    checks++;
    if (sck_fall_cyc !== a + CLK_DIV) begin
      failures++;
      $display("FAIL basic_setup got=%0d exp=%0d", sck_fall_cyc, a + CLK_DIV);
    end
    checks++;
    if (low_len !== 33 * CLK_DIV) begin
      failures++;
      $display("FAIL basic_sync_low got=%0d exp=%0d", low_len, 33 * CLK_DIV);
    end
    checks++;
    if (done_cnt !== dc + 1) begin
      failures++;
      $display("FAIL basic_done_cnt got=%0d exp=%0d", done_cnt, dc + 1);
    end
    checks++;
    if (done_cyc !== a + 33 * CLK_DIV) begin
      failures++;
      $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc,
               a + 33 * CLK_DIV);
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL basic_mosi_stable got=%0d exp=0", viol);
    end
`ifndef SPI_DAC_DOUBLE_BUFFER_EN
    // Ready visible in the 341st cycle after the accepting edge.
    checks++;
    if (rdy_cyc !== a + 34 * CLK_DIV) begin
      failures++;
      $display("FAIL basic_ready_back got=%0d exp=%0d", rdy_cyc,
               a + 34 * CLK_DIV);
    end
    checks++;
    if (busy_rdy !== br) begin
      failures++;
      $display("FAIL basic_ready_busy got=%0d exp=%0d", busy_rdy, br);
    end
`endif
  endtask

`ifdef SPI_DAC_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    int a1, a2, w;
    logic [31:0] rx, ex;
    accept_pair(12'h123, 12'h456, 1'b0, a1, w);
    repeat (150) @(negedge clk);
    accept_pair(12'h001, 12'hFFE, 1'b0, a2, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL dbuf_immediate got=%0d exp=0", w);
    end
    for (int i = 0; i < 2; i++) begin
      get_frame(rx, ex);
      checks++;
      if (rx !== ex) begin
        failures++;
        $display("FAIL dbuf_frame%0d got=%h exp=%h", i, rx, ex);
      end
    end
    repeat (40) @(negedge clk);
    checks++;
    if (high_len !== CLK_DIV) begin
      failures++;
      $display("FAIL dbuf_gap got=%0d exp=%0d", high_len, CLK_DIV);
    end
    checks++;
    if (fall_cyc !== a1 + 34 * CLK_DIV) begin
      failures++;
      $display("FAIL dbuf_start got=%0d exp=%0d", fall_cyc,
               a1 + 34 * CLK_DIV);
    end
  endtask
`else
  task automatic test_back_to_back();
    int a1, a2, w, br;
    logic [31:0] rx, ex;
    br = busy_rdy;
    accept_pair(12'h7E1, 12'h18C, 1'b1, a1, w);
    accept_pair(12'h0F0, 12'hF0F, 1'b0, a2, w);
    checks++;
    if (a2 - a1 !== 34 * CLK_DIV + 1) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", a2 - a1,
               34 * CLK_DIV + 1);
    end
    checks++;
    if (busy_rdy !== br) begin
      failures++;
      $display("FAIL b2b_ready_busy got=%0d exp=%0d", busy_rdy, br);
    end
    for (int i = 0; i < 2; i++) begin
      get_frame(rx, ex);
      checks++;
      if (rx !== ex) begin
        failures++;
        $display("FAIL b2b_frame%0d got=%h exp=%h", i, rx, ex);
      end
    end
    repeat (40) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    int a, w, n, dc;
    logic [31:0] rx, ex;
    accept_pair(12'h9C3, 12'h26B, 1'b0, a, w);
    n = 0;
    while (nbits < 9 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    void'(exp_q.pop_back());
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if (spi_sync_no !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_sync got=%b exp=1", spi_sync_no);
    end
    checks++;
    if (spi_sck_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_sck got=%b exp=1", spi_sck_o);
    end
    checks++;
    if (spi_mosi_o !== 2'b00) begin
      failures++;
      $display("FAIL mid_rst_mosi got=%b exp=00", spi_mosi_o);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_ready got=%b exp=0", ready_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_release_ready got=%b exp=1", ready_o);
    end
    repeat (400) @(negedge clk);
    checks++;
    if (done_cnt !== dc) begin
      failures++;
      $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt, dc);
    end
    checks++;
    if (rx_q.size() !== 0) begin
      failures++;
      $display("FAIL mid_no_frame got=%0d exp=0", rx_q.size());
    end
    accept_pair(12'h3A7, 12'hC58, 1'b0, a, w);
    get_frame(rx, ex);
    checks++;
    if (rx !== ex) begin
      failures++;
      $display("FAIL mid_clean_frame got=%h exp=%h", rx, ex);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_latch();
    int a, w;
    logic [31:0] rx, ex;
    accept_pair(12'h5A5, 12'h0F0, 1'b0, a, w);
    for (int i = 0; i < 360; i++) begin
      @(negedge clk);
      data0_i = 12'($urandom);
      data1_i = 12'($urandom);
    end
    get_frame(rx, ex);
    checks++;
    if (rx[15:0] !== ex[15:0]) begin
      failures++;
      $display("FAIL latch_ch0 got=%h exp=%h", rx[15:0], ex[15:0]);
    end
    checks++;
    if (rx[31:16] !== ex[31:16]) begin
      failures++;
      $display("FAIL latch_ch1 got=%h exp=%h", rx[31:16], ex[31:16]);
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL final_mosi_stable got=%0d exp=0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef SPI_DAC_DOUBLE_BUFFER_EN
    test_double_buffer();
`else
    test_back_to_back();
`endif
    test_reset_mid();
    test_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_dac.md
SPI_DAC -- requirements
Module: spi_dac

Interface
REQ-001 Parameter CLK_DIV, default 10: system clk cycles per SCK half-period; legal range 2..255.
REQ-002 Parameter PD_MODE, default 2'b00: power-down bits sent in every frame (00 = normal operation).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  sample pair available on data0_i/data1_i.
REQ-006 ready_o  output  1  block can accept a sample pair; transfer occurs when valid_i && ready_o on a clk edge.
REQ-007 data0_i  input  12  channel 0 DAC code, unsigned.
REQ-008 data1_i  input  12  channel 1 DAC code, unsigned.
REQ-009 spi_sync_no  output  1  shared frame sync / chip select, active low.
REQ-010 spi_sck_o  output  1  shared serial clock, idles high.
REQ-011 spi_mosi_o  output  2  serial data; bit 0 = channel 0, bit 1 = channel 1.
REQ-012 done_o  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 Frame word per channel shall be 16 bits: {2'b00, PD_MODE, data[11:0]}, sent MSB first; both channels shift in lockstep.
REQ-014 On accept, data0_i/data1_i shall be latched; input changes after accept shall not affect the frame.
REQ-015 The FSM shall have states IDLE, SETUP, SHIFT, HOLD; IDLE->SETUP on accept, SETUP->SHIFT after CLK_DIV cycles, SHIFT->HOLD after 16 bits, HOLD->IDLE (or SETUP if a frame is pending) after CLK_DIV cycles.
REQ-016 In the cycle after accept (T+1), spi_sync_no shall go 0 and spi_mosi_o shall present bit 15; SCK shall remain high for CLK_DIV cycles (SETUP).
REQ-017 Each bit period shall be CLK_DIV cycles SCK low followed by CLK_DIV cycles SCK high; the DAC samples on the SCK falling edge.
REQ-018 spi_mosi_o shall change only on SCK rising edges (bits 14..0) and shall be stable for the whole low half-period.
REQ-019 After the high half of bit 0, spi_sync_no shall return to 1, spi_mosi_o shall be 2'b00, and done_o shall pulse for that one cycle.
REQ-020 HOLD shall keep spi_sync_no high for exactly CLK_DIV cycles before the next frame may assert it.
REQ-021 spi_sync_no low time shall be 33*CLK_DIV cycles; accept-to-ready (non-buffered) shall be 34*CLK_DIV+1 cycles (341 at default).
REQ-022 The bit counter shall count 15 down to 0 with no wrap; the divider counter shall reset to 0 at each SCK toggle and state change.
REQ-023 valid_i deasserting without a transfer shall have no effect; valid_i while ready_o=0 shall not be accepted.

Reset
REQ-024 On rst_n=0, at any time including mid-frame, outputs shall immediately become spi_sync_no=1, spi_sck_o=1, spi_mosi_o=2'b00, done_o=0, ready_o=0, with FSM=IDLE, counters=0, and any buffered sample discarded.
REQ-025 ready_o shall assert in the first clk cycle after rst_n deasserts; an aborted frame shall not produce done_o.

Configuration
REQ-026 Macro SPI_DAC_DOUBLE_BUFFER_EN defined: a one-entry pending buffer shall exist; ready_o=1 whenever it is empty (including during SETUP/SHIFT/HOLD), and a pending pair shall start SETUP in the cycle after HOLD ends.
REQ-027 Macro SPI_DAC_DOUBLE_BUFFER_EN undefined: no pending buffer; ready_o=1 only in IDLE.

Verification
REQ-028 Reset asserted then released -> outputs at REQ-024 values during reset; ready_o=1 on first cycle after release.
REQ-029 CLK_DIV=10, accept data0_i=0xA5C, data1_i=0x3FF -> words 0x0A5C/0x03FF sampled on SCK falls, SYNC low 330 cycles, single done_o, ready_o back at T+341.
REQ-030 Macro defined, second pair 0x001/0xFFE offered at mid-frame -> accepted immediately; SYNC high exactly 10 cycles between frames; second frame words 0x0001/0x0FFE.
REQ-031 Macro undefined, valid_i held high through frame -> ready_o low throughout; second accept only at T+341.
REQ-032 rst_n pulsed low during SHIFT at bit 7 -> SYNC high and SCK high asynchronously, no done_o, next frame transmits cleanly.
REQ-033 data0_i changed every cycle after accept -> transmitted word equals value latched at accept.
